clock_div_multi: RTL and testbench

CLOCK_DIV_MULTI -- requirements
Module: clock_div_multi

---
 rtl/clock_div_multi.sv | 89 ++++++++
 tb/tb_clock_div_multi.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/clock_div_multi.sv
// -----------------------------------------------------------------------------
// clock_div_multi
//
// A bank of NUM_CH independent programmable clock dividers, all running in
// the CLK_IN domain. Each channel owns a half-period register hp and a
// counter cnt. While enabled, the counter runs 0..hp. When it reaches hp it
// clears, CLK_OUT toggles and TICK pulses for one cycle. The output period is
// therefore 2*(hp+1) CLK_IN cycles with exactly 50% duty.
//
// Ports
//   CLK_IN   in   1       only clock, rising edge
//   RST_N    in   1       asynchronous active-low reset (deassert synchronously
//                         at system level; no synchroniser inside)
//   EN       in   NUM_CH  per-channel run enable, level-sensitive
//   WR_EN    in   1       half-period write strobe
//   WR_SEL   in   SEL_W   write target channel (>= NUM_CH is ignored)
//   WR_DATA  in   CNT_W   new half-period value
//   CLK_OUT  out  NUM_CH  divided clock per channel, registered
//   TICK     out  NUM_CH  one-cycle pulse on each CLK_OUT toggle, registered
//
// Write interface semantics: WR_EN is a plain strobe with no ready/back-
// pressure. Every cycle with WR_EN=1 is exactly one write, accepted on that
// rising edge, regardless of the target channel's enable.
// -----------------------------------------------------------------------------
module clock_div_multi #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int DEFAULT_HP = 199999,
  parameter int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK_IN,
  input  logic              RST_N,
  input  logic [NUM_CH-1:0] EN,
  input  logic              WR_EN,
  input  logic [SEL_W-1:0]  WR_SEL,
  input  logic [CNT_W-1:0]  WR_DATA,
  output logic [NUM_CH-1:0] CLK_OUT,
  output logic [NUM_CH-1:0] TICK
);

  // Reset value of every half-period register, truncated to the counter width.
  localparam logic [CNT_W-1:0] HP_RST = CNT_W'(DEFAULT_HP);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    localparam logic [31:0] CH_IDX = ch;

    logic [CNT_W-1:0] hp_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clk_q;
    logic             tick_q;
    logic             wr_hit;
    logic             terminal;

    // Out-of-range selects never match any channel, so such writes vanish.
    assign wr_hit   = WR_EN && (32'(WR_SEL) == CH_IDX);
    assign terminal = (cnt_q == hp_q);

    // Priority: write > disable > terminal count > count.
    // A write restarts the half-period from 0 under the new hp, but leaves the
    // output level alone so the channel does not glitch on reprogramming.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
        hp_q   <= HP_RST;
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (wr_hit) begin
        hp_q   <= WR_DATA;
        cnt_q  <= '0;
        tick_q <= 1'b0;
      end else if (!EN[ch]) begin
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (terminal) begin
        cnt_q  <= '0;
        clk_q  <= ~clk_q;
        tick_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
        tick_q <= 1'b0;
      end
    end

    assign CLK_OUT[ch] = clk_q;
    assign TICK[ch]    = tick_q;
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clock_div_multi
//
// Bench for clock_div_multi with NUM_CH=3, CNT_W=8, DEFAULT_HP=3.
// A table of per-cycle {inputs, expected CLK_OUT, expected TICK} records walks
// through: default divide-by-8, hp=0 divide-by-2, reprogramming at terminal
// count, enable drop/re-assert, out-of-range writes. Expected values are
// pushed to a scoreboard queue as each vector is driven and popped after the
// following rising edge. Hand-written sequences cover the initial reset and
// an asynchronous reset pulse between clock edges.
// -----------------------------------------------------------------------------
module tb_clock_div_multi;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int SEL_W  = 2;

  // ---------------- clock / reset ----------------
  logic              CLK_IN = 1'b0;
  logic              RST_N  = 1'b0;
  logic [NUM_CH-1:0] EN     = '0;
  logic              WR_EN  = 1'b0;
  logic [SEL_W-1:0]  WR_SEL = '0;
  logic [CNT_W-1:0]  WR_DATA = '0;
  logic [NUM_CH-1:0] CLK_OUT;
  logic [NUM_CH-1:0] TICK;

  always #5 CLK_IN = ~CLK_IN;

  clock_div_multi #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .DEFAULT_HP(3),
    .SEL_W     (SEL_W)
  ) dut (
    .CLK_IN (CLK_IN),
    .RST_N  (RST_N),
    .EN     (EN),
    .WR_EN  (WR_EN),
    .WR_SEL (WR_SEL),
    .WR_DATA(WR_DATA),
    .CLK_OUT(CLK_OUT),
    .TICK   (TICK)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] en;
    logic       wr_en;
    logic [1:0] wr_sel;
    logic [7:0] wr_data;
    logic [2:0] exp_clk;
    logic [2:0] exp_tick;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [2:0] en, input logic wr_en,
                         input logic [1:0] wr_sel, input logic [7:0] wr_data,
                         input logic [2:0] exp_clk, input logic [2:0] exp_tick);
    vec_t v;
    v.en = en; v.wr_en = wr_en; v.wr_sel = wr_sel; v.wr_data = wr_data;
    v.exp_clk = exp_clk; v.exp_tick = exp_tick;
    vecs.push_back(v);
  endtask

  task automatic add_rep(input int n, input logic [2:0] en,
                         input logic [2:0] exp_clk, input logic [2:0] exp_tick);
    for (int k = 0; k < n; k++) add_vec(en, 1'b0, 2'd0, 8'd0, exp_clk, exp_tick);
  endtask

  // ---------------- scoreboard ----------------
  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, check the result just after the
  // next rising edge.
  task automatic apply(input string tag, input int i);
    vec_t v;
    logic [5:0] e;
    v = vecs[i];
    @(negedge CLK_IN);
    EN      = v.en;
    WR_EN   = v.wr_en;
    WR_SEL  = v.wr_sel;
    WR_DATA = v.wr_data;
    exp_q.push_back({v.exp_clk, v.exp_tick});
    @(posedge CLK_IN);
    #1;
    e = exp_q.pop_front();
    check($sformatf("%s%0d_clk", tag, i + 1), CLK_OUT, e[5:3]);
    check($sformatf("%s%0d_tick", tag, i + 1), TICK, e[2:0]);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test ----------------
  initial begin
    bit seen;

    // Default hp=3: CLK_OUT[0] rises on edge 4, period 8, TICK every 4.
    add_rep(3, 3'b001, 3'b000, 3'b000);
    add_vec(3'b001, 1'b0, 2'd0, 8'd0, 3'b001, 3'b001);
    add_rep(3, 3'b001, 3'b001, 3'b000);
    add_vec(3'b001, 1'b0, 2'd0, 8'd0, 3'b000, 3'b001);
    add_rep(3, 3'b001, 3'b000, 3'b000);
    add_vec(3'b001, 1'b0, 2'd0, 8'd0, 3'b001, 3'b001);
    // ch1: write hp=0 while disabled, then enable: toggles every cycle.
    add_vec(3'b001, 1'b1, 2'd1, 8'd0, 3'b001, 3'b000);
    add_vec(3'b011, 1'b0, 2'd0, 8'd0, 3'b011, 3'b010);
    add_vec(3'b011, 1'b0, 2'd0, 8'd0, 3'b001, 3'b010);
    add_vec(3'b011, 1'b0, 2'd0, 8'd0, 3'b010, 3'b011);
    add_vec(3'b011, 1'b0, 2'd0, 8'd0, 3'b000, 3'b010);
    add_vec(3'b011, 1'b0, 2'd0, 8'd0, 3'b010, 3'b010);
    add_vec(3'b001, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000);
    // ch0: write hp=5 exactly when cnt=3; write beats terminal count.
    add_vec(3'b001, 1'b1, 2'd0, 8'd5, 3'b000, 3'b000);
    add_rep(5, 3'b001, 3'b000, 3'b000);
    add_vec(3'b001, 1'b0, 2'd0, 8'd0, 3'b001, 3'b001);
    add_rep(5, 3'b001, 3'b001, 3'b000);
    add_vec(3'b001, 1'b0, 2'd0, 8'd0, 3'b000, 3'b001);
    add_rep(5, 3'b001, 3'b000, 3'b000);
    add_vec(3'b001, 1'b0, 2'd0, 8'd0, 3'b001, 3'b001);
    // Drop EN[0] while high, then re-enable: first rise on 6th enabled edge.
    add_rep(2, 3'b000, 3'b000, 3'b000);
    add_rep(5, 3'b001, 3'b000, 3'b000);
    add_vec(3'b001, 1'b0, 2'd0, 8'd0, 3'b001, 3'b001);
    // Out-of-range writes (WR_SEL=3) with ch0 and ch2 running: no effect.
    add_vec(3'b101, 1'b1, 2'd3, 8'd0,   3'b001, 3'b000);
    add_vec(3'b101, 1'b1, 2'd3, 8'hff,  3'b001, 3'b000);
    add_vec(3'b101, 1'b1, 2'd3, 8'd1,   3'b001, 3'b000);
    add_vec(3'b101, 1'b0, 2'd0, 8'd0,   3'b101, 3'b100);
    add_vec(3'b101, 1'b0, 2'd0, 8'd0,   3'b101, 3'b000);
    add_vec(3'b101, 1'b0, 2'd0, 8'd0,   3'b100, 3'b001);
    add_vec(3'b101, 1'b0, 2'd0, 8'd0,   3'b100, 3'b000);
    add_vec(3'b101, 1'b0, 2'd0, 8'd0,   3'b000, 3'b100);

    // Reset holds everything at 0 even with clocks and enables active.
    EN = 3'b111;
    repeat (3) @(posedge CLK_IN);
    #1;
    check("reset_clk", CLK_OUT, 3'b000);
    check("reset_tick", TICK, 3'b000);
    @(negedge CLK_IN);
    RST_N = 1'b1;
    EN    = 3'b000;

    for (int i = 0; i < vecs.size(); i++) apply("vec", i);

    // Run on (EN=101) until ch0 rises; ch2 toggles on the same edge.
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge CLK_IN);
      #1;
      if (CLK_OUT[0]) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_rise: CLK_OUT[0] never rose within 20 cycles");
    end
    check("pre_reset_clk", CLK_OUT, 3'b101);
    check("pre_reset_tick", TICK, 3'b101);

    // Asynchronous reset pulse between edges clears outputs immediately.
    #2;
    RST_N = 1'b0;
    #1;
    check("async_reset_clk", CLK_OUT, 3'b000);
    check("async_reset_tick", TICK, 3'b000);
    @(negedge CLK_IN);
    RST_N = 1'b1;
    EN    = 3'b000;

    // hp of ch0 must be back to 3: replay the default divide-by-8 vectors.
    for (int i = 0; i < 12; i++) apply("post_reset", i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
